// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that shares one FIFO push port among NREQ producers, up to BURST words per ownership.
// Latency: zero-cycle acceptance; grant/push/data_out are combinational, owner/busy are registered.
// Backpressure: fifo_full blocks every grant; the owner keeps its burst while stalled.
module fifo_push_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    output logic [NREQ-1:0]       grant,
    output logic                  push,
    output logic [WIDTH-1:0]      data_out,
    output logic [IDW-1:0]        owner,
    output logic                  busy
);

    localparam int CW = $clog2(BURST + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  BURST_C  = CW'(BURST);
    localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [2*NREQ-1:0] req_sh;
    logic [NREQ-1:0]   req_rot;
    logic              cand_vld;
    logic [IDW:0]      cand_off;
    logic [IDW:0]      cand_sum;
    logic [IDW-1:0]    cand;
    logic              own_req;

    // Index wrap that also works when NREQ is not a power of two.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Rotate requests so bit 0 is the current priority start.
    assign req_sh  = {req, req} >> rr_ptr_q;
    assign req_rot = req_sh[NREQ-1:0];

    // Lowest set bit of the rotated vector is the round-robin winner.
    always_comb begin
        cand_vld = 1'b0;
        cand_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                cand_vld = 1'b1;
                cand_off = (IDW + 1)'(k);
            end
        end
    end

    assign cand_sum = {1'b0, rr_ptr_q} + cand_off;
    assign cand     = (cand_sum >= NREQ_W) ? IDW'(cand_sum - NREQ_W) : cand_sum[IDW-1:0];

    // Request bit of the current owner.
    always_comb begin
        own_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDW'(i)) begin
                own_req = req[i];
            end
        end
    end

    // Grant decision and next-state; everything is quiet while rst is high.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        grant    = '0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (cand_vld && !fifo_full) begin
                        grant   = NREQ'(1) << cand;
                        owner_d = cand;
                        cnt_d   = CW'(1);
                        if (BURST == 1) begin
                            rr_ptr_d = next_idx(cand);
                        end else begin
                            state_d = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!own_req) begin
                        // Owner gave up mid-burst: one idle bubble, then rotate.
                        state_d  = S_IDLE;
                        rr_ptr_d = next_idx(owner_q);
                        cnt_d    = '0;
                    end else if (!fifo_full) begin
                        grant = NREQ'(1) << owner_q;
                        if (cnt_q + CW'(1) == BURST_C) begin
                            state_d  = S_IDLE;
                            rr_ptr_d = next_idx(owner_q);
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Steer the granted word onto the FIFO data bus; zero when idle.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                data_out = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign push  = |grant;
    assign owner = owner_q;
    assign busy  = (state_q == S_HOLD);

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           fifo_full;
    logic [N-1:0]   grant;
    logic           push;
    logic [W-1:0]   data_out;
    logic [1:0]     owner;
    logic           busy;

    logic [W-1:0] d [N];

    // Reference state: what the arbiter should be doing, in plain integers.
    bit m_hold;
    int m_owner, m_rr, m_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [N-1:0] last_grant;
    logic [W-1:0] last_data;
    logic         last_busy_pre;
    logic         last_busy;
    logic [1:0]   last_owner;

    logic [N-1:0] req_r;
    logic [W-1:0] rot_seen [9];
    logic [W-1:0] rot_exp  [9];

    assign data_in = {d[3], d[2], d[1], d[0]};

    fifo_push_arbiter #(.NREQ(N), .WIDTH(W), .BURST(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .fifo_full (fifo_full),
        .grant     (grant),
        .push      (push),
        .data_out  (data_out),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle, advance the model.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic f);
        int           c;
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        rst       = r;
        req       = rq;
        fifo_full = f;
        #3;
        c = -1;
        if (!r) begin
            if (!m_hold) begin
                for (int k = N - 1; k >= 0; k--)
                    if (bit_at(rq, (m_rr + k) % N)) c = (m_rr + k) % N;
                if (f) c = -1;
            end else if (bit_at(rq, m_owner) && !f) begin
                c = m_owner;
            end
        end
        eg = (c >= 0) ? (N'(1) << c) : '0;
        ed = '0;
        for (int i = 0; i < N; i++) if (i == c) ed = d[i];
        chk("grant", 32'(grant), 32'(eg));
        chk("push", 32'(push), 32'(eg != '0));
        chk("data_out", 32'(data_out), 32'(ed));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_hold));
        last_grant    = grant;
        last_data     = data_out;
        last_busy_pre = busy;
        @(posedge clk);
        #1;
        if (r) begin
            m_hold = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
        end else if (!m_hold) begin
            if (c >= 0) begin
                m_owner = c;
                m_cnt   = 1;
                if (B == 1) m_rr = (c + 1) % N;
                else        m_hold = 1;
            end
        end else if (!bit_at(rq, m_owner)) begin
            m_hold = 0; m_rr = (m_owner + 1) % N; m_cnt = 0;
        end else if (c >= 0) begin
            m_cnt++;
            if (m_cnt == B) begin
                m_hold = 0; m_rr = (m_owner + 1) % N; m_cnt = 0;
            end
        end
        last_busy  = busy;
        last_owner = owner;
    endtask

    initial begin
        m_hold = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) d[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 9; i++) rot_exp[i] = 8'hA0 + 8'((i / 2) % N);
        rst = 1'b1; req = '1; fifo_full = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with every requester asking.
        cyc(1, 4'b1111, 0);
        cyc(1, 4'b1111, 0);
        chk("rst_grant", 32'(last_grant), 32'h0);
        chk("rst_busy", 32'(last_busy), 32'h0);
        chk("rst_owner", 32'(last_owner), 32'h0);

        // Rotation: two words per requester, no gap at hand-over.
        for (int i = 0; i < 9; i++) begin
            cyc(0, 4'b1111, 0);
            if (i == 0) chk("release_grant", 32'(last_grant), 32'h1);
            rot_seen[i] = last_data;
        end
        for (int i = 0; i < 9; i++) chk($sformatf("rot_data%0d", i), 32'(rot_seen[i]), 32'(rot_exp[i]));

        // Finish requester 0's burst, then requester 1 takes its first word.
        cyc(0, 4'b1111, 0);
        cyc(0, 4'b1111, 0);
        chk("stall_pre_grant", 32'(last_grant), 32'h2);

        // FIFO full for three cycles mid-burst.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'b1111, 1);
            chk("stall_push", 32'(last_grant != '0), 32'h0);
            chk("stall_busy", 32'(last_busy), 32'h1);
            chk("stall_owner", 32'(last_owner), 32'h1);
        end
        cyc(0, 4'b1111, 0);
        chk("stall_resume_data", 32'(last_data), 32'hA1);
        cyc(0, 4'b1111, 0);
        chk("stall_next_grant", 32'(last_grant), 32'h4);

        // Reset pulse while requester 2 is mid-burst.
        cyc(1, 4'b1111, 0);
        cyc(0, 4'b1111, 0);
        chk("midrst_grant", 32'(last_grant), 32'h1);

        // Requester 0 drops after its first word: one bubble, then requester 2.
        cyc(0, 4'b0100, 0);
        chk("drop_bubble", 32'(last_grant), 32'h0);
        chk("drop_busy", 32'(last_busy_pre), 32'h1);
        cyc(0, 4'b0100, 0);
        chk("drop_next", 32'(last_grant), 32'h4);

        // Requester 2 leaves; requester 3 alone streams with no rotation gap.
        cyc(0, 4'b1000, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 4'b1000, 0);
            chk("lone_grant", 32'(last_grant), 32'h8);
            chk("lone_busy", 32'(last_busy), 32'((i % 2) == 0));
        end

        // Randomised traffic obeying the hold-until-granted handshake.
        req_r = '0;
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 60) == 0, req_r, ($urandom % 4) == 0);
            for (int i = 0; i < N; i++) begin
                if (last_grant[i]) begin
                    if ($urandom % 2 == 0) req_r[i] = 1'b0;
                    else                   d[i] = 8'($urandom);
                end else if (!req_r[i] && ($urandom % 3 == 0)) begin
                    req_r[i] = 1'b1;
                    d[i]     = 8'($urandom);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter that shares the single push port of a `fifo` instance among `NREQ` producers. Each granted producer may push up to `BURST` consecutive words before ownership rotates. Backpressure comes from the FIFO's `full` flag. Sits directly in front of `fifo`: `push` drives `fifo.push` and `data_out` drives `fifo.data_in`.

## Interface
- `NREQ`, default 4: number of requesters; must be ≥ 2.
- `WIDTH`, default 8: data word width; matches the FIFO `WIDTH`.
- `BURST`, default 2: maximum words accepted per ownership period; must be ≥ 1.
- `IDW`, default `$clog2(NREQ)`: requester index width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req` in NREQ: `req[i]` means requester i holds a valid word.
- `data_in` in NREQ*WIDTH: requester i's word is `data_in[i*WIDTH +: WIDTH]`.
- `fifo_full` in 1: FIFO `full` flag.
- `grant` out NREQ: one-hot acceptance strobe; `grant[i]` means requester i's word is pushed this cycle.
- `push` out 1: `|grant`; drives FIFO push.
- `data_out` out WIDTH: granted requester's word; 0 when `push`=0.
- `owner` out IDW: index of current/last owner.
- `busy` out 1: state is HOLD.

## Operation
- Registered state:
  - `state` ∈ {IDLE, HOLD}
  - `owner` (IDW)
  - `rr_ptr` (IDW), the next priority start
  - `cnt` ($clog2(BURST+1) bits), words pushed in the current ownership
- Reset (`rst`=1 at edge): state=IDLE, owner=0, rr_ptr=0, cnt=0.
  - While `rst` is high, `grant`, `push` and `data_out` are forced to 0 regardless of `req`.
- IDLE:
  - Candidate = first i with `req[i]`=1, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - If a candidate exists and `fifo_full`=0: `grant[cand]`=1 and `push`=1 this cycle.
  - Next cycle: owner=cand, cnt=1.
  - If BURST=1: stay IDLE and set rr_ptr=cand+1 mod NREQ. Otherwise go to HOLD.
  - If `fifo_full`=1: no grant and no state change (owner and rr_ptr unchanged).
- HOLD:
  - `req[owner]`=1 and `fifo_full`=0:
    - push owner's word; cnt←cnt+1.
    - If cnt+1 = BURST: next state IDLE, rr_ptr←owner+1 mod NREQ, cnt←0.
  - `req[owner]`=1 and `fifo_full`=1: stall. No grant; cnt, owner and state held.
  - `req[owner]`=0: no grant this cycle; next state IDLE, rr_ptr←owner+1, cnt←0. This is a one-cycle bubble.
  - Other requesters are ignored while in HOLD.
- Handshake:
  - A requester keeps `req` and data stable until it sees its `grant` bit.
  - A requester may drop `req` after any grant.
- Grant is never issued while `fifo_full`=1. The arbiter therefore never overflows the FIFO.
- Pop activity on the FIFO is outside this block. A pop that clears `full` is seen via `fifo_full` in the next cycle.
- rr_ptr and owner wrap modulo NREQ. NREQ need not be a power of two: the index NREQ-1 increments to 0.

## Timing
- `grant`, `push`, `data_out` are combinational from registered state plus the current `req`, `data_in`, `fifo_full`. Zero-cycle acceptance: the word is written into the FIFO at the same edge.
- `owner`, `busy` are direct register outputs; they update at the edge after the deciding cycle.
- Peak throughput is 1 word/cycle. Ownership rotation costs no cycle unless the owner drops `req` mid-burst (1-cycle bubble).
- Worst-case wait for a continuously requesting producer with the FIFO never full: (NREQ-1)·BURST cycles.
- Reset asserted mid-HOLD aborts the burst. The next cycle after `rst` falls is IDLE with rr_ptr=0.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=4'b1111 → `grant`=0, `push`=0, `busy`=0, `owner`=0. In the first cycle after release, `grant`=4'b0001.
- Rotation (NREQ=4, BURST=2): all `req`=1, `fifo_full`=0, data_in[i]=8'hA0+i → the `data_out` sequence is A0,A0,A1,A1,A2,A2,A3,A3,A0, with `push`=1 every cycle.
- Full stall: owner=1 with cnt=1, then `fifo_full`=1 for 3 cycles → `push`=0, `busy`=1, `owner`=1 throughout. After `full` drops: one push of A1, then the next cycle grants requester 2.
- Early drop: `req[0]` falls after its first grant while `req[2]`=1 → one cycle with `grant`=0 and `busy`=1, then `grant`=4'b0100.
- Lone requester: only `req[3]`=1 for 6 cycles → `grant[3]`=1 every cycle with no bubble at rotation; `busy` pattern 1,0,1,0,1,0.
- Reset mid-burst: `rst` pulses while owner=2 with cnt=1 → next cycle IDLE, and with all `req` high `grant`=4'b0001.
